// File: rtl/coin_payer.sv
// coin_payer: customer-side coin sequencer for the vending machine.
//
// Accepts a payment request (counts of one-unit and half-unit coins), feeds
// the coins into the machine one per cycle separated by idle gaps, watches
// the machine's response and reports dispense / change / timeout together
// with the number of coins left unsent.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        request pulse, only honoured in IDLE
//   n_half[2:0]  half-unit coins to pay (code 2'b01)
//   n_one[2:0]   one-unit coins to pay (code 2'b10)
//   vend_out[1:0] machine response: 10 dispense, 11 dispense+change
//   coin[1:0]    coin code driven to the machine (never 2'b11)
//   busy         request in progress, through the done cycle
//   done         one-cycle completion pulse
//   dispensed, change, timeout_err, left_half, left_one
//                result, valid with done and held until the next start
//
// Handshake: start is a single-cycle request accepted only while busy is
// low; exactly one done pulse answers every accepted start.
//
// The FSM state is the typed register state_q so checkers can bind to it.
module coin_payer #(
    parameter int GAP     = 1,
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] n_half,
    input  logic [2:0] n_one,
    input  logic [1:0] vend_out,
    output logic [1:0] coin,
    output logic       busy,
    output logic       done,
    output logic       dispensed,
    output logic       change,
    output logic       timeout_err,
    output logic [2:0] left_half,
    output logic [2:0] left_one
);

    localparam int GW = $clog2(GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_HALF = 2'b01;
    localparam logic [1:0] COIN_ONE  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    rem_half_q, rem_half_d;
    logic [2:0]    rem_one_q, rem_one_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]    coin_q, coin_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          disp_q, disp_d;
    logic          chg_q, chg_d;
    logic          to_q, to_d;
    logic [2:0]    left_half_q, left_half_d;
    logic [2:0]    left_one_q, left_one_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_half_q  <= '0;
            rem_one_q   <= '0;
            gap_cnt_q   <= '0;
            to_cnt_q    <= '0;
            coin_q      <= COIN_NONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            disp_q      <= 1'b0;
            chg_q       <= 1'b0;
            to_q        <= 1'b0;
            left_half_q <= '0;
            left_one_q  <= '0;
        end else begin
            state_q     <= state_d;
            rem_half_q  <= rem_half_d;
            rem_one_q   <= rem_one_d;
            gap_cnt_q   <= gap_cnt_d;
            to_cnt_q    <= to_cnt_d;
            coin_q      <= coin_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            disp_q      <= disp_d;
            chg_q       <= chg_d;
            to_q        <= to_d;
            left_half_q <= left_half_d;
            left_one_q  <= left_one_d;
        end
    end

    // Outputs are registered, so they are computed here from the state being
    // entered. The remaining counters still include the coin on the wire
    // while in SEND; it is subtracted on the way out of SEND.
    always_comb begin
        state_d     = state_q;
        rem_half_d  = rem_half_q;
        rem_one_d   = rem_one_q;
        gap_cnt_d   = gap_cnt_q;
        to_cnt_d    = to_cnt_q;
        coin_d      = COIN_NONE;
        done_d      = 1'b0;
        disp_d      = disp_q;
        chg_d       = chg_q;
        to_d        = to_q;
        left_half_d = left_half_q;
        left_one_d  = left_one_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_one_d   = n_one;
                    rem_half_d  = n_half;
                    disp_d      = 1'b0;
                    chg_d       = 1'b0;
                    to_d        = 1'b0;
                    left_half_d = '0;
                    left_one_d  = '0;
                    if (n_one == 3'd0 && n_half == 3'd0) begin
                        state_d = S_DONE;
                        to_d    = 1'b1;
                    end else begin
                        state_d = S_SEND;
                        coin_d  = (n_one != 3'd0) ? COIN_ONE : COIN_HALF;
                    end
                end
            end

            S_SEND: begin
                state_d   = S_GAP;
                gap_cnt_d = GW'(1);
                if (rem_one_q != 3'd0) begin
                    rem_one_d = rem_one_q - 3'd1;
                end else begin
                    rem_half_d = rem_half_q - 3'd1;
                end
            end

            S_GAP: begin
                // A dispense seen on the last gap cycle still wins.
                if (vend_out[1]) begin
                    state_d = S_DONE;
                    disp_d  = 1'b1;
                    chg_d   = vend_out[0];
                end else if (gap_cnt_q == GW'(GAP)) begin
                    if (rem_one_q != 3'd0 || rem_half_q != 3'd0) begin
                        state_d = S_SEND;
                        coin_d  = (rem_one_q != 3'd0) ? COIN_ONE : COIN_HALF;
                    end else begin
                        state_d  = S_WAIT;
                        to_cnt_d = TW'(1);
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            S_WAIT: begin
                if (vend_out[1]) begin
                    state_d = S_DONE;
                    disp_d  = 1'b1;
                    chg_d   = vend_out[0];
                end else if (to_cnt_q == TW'(TIMEOUT)) begin
                    state_d = S_DONE;
                    to_d    = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entering DONE: raise the pulse and publish what was left unsent.
        if (state_d == S_DONE) begin
            done_d      = 1'b1;
            left_half_d = rem_half_d;
            left_one_d  = rem_one_d;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign coin        = coin_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dispensed   = disp_q;
    assign change      = chg_q;
    assign timeout_err = to_q;
    assign left_half   = left_half_q;
    assign left_one    = left_one_q;

endmodule

// File: doc/coin_payer.md
# coin_payer

Customer-side coin sequencer for the synchronous vending-machine FSM in this codebase. It accepts a payment request (a count of half-unit and one-unit coins) and drives the coin codes into the machine's 2-bit `in` port, one coin at a time with idle gaps. It watches the machine's 2-bit `out` response and reports dispense, change, unused coins, or timeout. It sits between the test/host logic and the vending machine, as the initiator of the coin protocol.

## Interface
- `GAP`, default 1: idle (2'b00) cycles inserted after each coin. Must be ≥1.
- `TIMEOUT`, default 8: cycles to wait for dispense after the last coin's gap. Must be ≥1.

Ports:
- `clk` input 1: single clock. Everything is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request pulse. Sampled only in IDLE.
- `n_half` input 3: number of half-unit coins (code 2'b01, value 1) to pay. Latched on accepted `start`.
- `n_one` input 3: number of one-unit coins (code 2'b10, value 2) to pay. Latched on accepted `start`.
- `vend_out` input 2: machine response. 2'b10 = dispense, 2'b11 = dispense + change, 2'b00 = none.
- `coin` output 2: coin code to the machine. 2'b11 is never driven.
- `busy` output 1: high from the cycle after `start` is accepted until the cycle `done` is asserted, inclusive.
- `done` output 1: one-cycle completion pulse.
- `dispensed` output 1: valid with `done` and held until the next accepted `start`.
- `change` output 1: valid with `done` and held until the next accepted `start`.
- `timeout_err` output 1: valid with `done` and held until the next accepted `start`.
- `left_half` output 3: unsent half-unit coins. Valid with `done` and held until the next accepted `start`.
- `left_one` output 3: unsent one-unit coins. Valid with `done` and held until the next accepted `start`.

## Operation
- All outputs are registered.
- Reset value of every output is 0, and the FSM resets to IDLE. Reset mid-payment forces `coin`=2'b00 immediately (asynchronous) and abandons the payment.
- States: IDLE, SEND, GAP, WAIT, DONE.
- **IDLE**: `start`=1 latches `n_one`/`n_half` into remaining counters and clears the result flags.
  - Zero coins requested (`n_one`=`n_half`=0): go to DONE with `timeout_err`=1.
  - Otherwise go to SEND.
- **SEND**: drive one coin for exactly one cycle and decrement its counter. One-unit coins are all sent before any half-unit coins. Go to GAP.
- **GAP**: drive 2'b00 for `GAP` cycles and sample `vend_out` every cycle.
  - `vend_out[1]`=1: set `dispensed`=1 and `change`=`vend_out[0]`, then go to DONE. Remaining coins are not sent.
  - Gap expires with coins remaining: go to SEND.
  - Gap expires with no coins remaining: go to WAIT.
- **WAIT**: drive 2'b00 for up to `TIMEOUT` cycles.
  - `vend_out[1]`=1: finish as in GAP.
  - Counter expires: `timeout_err`=1, go to DONE.
- **DONE**: pulse `done` for one cycle and copy the remaining counters to `left_half`/`left_one`. Go to IDLE.
- `start` outside IDLE is ignored.
- `vend_out` is ignored in IDLE, SEND and DONE.
- The gap counter is ceil(log2(GAP+1)) bits and the timeout counter is ceil(log2(TIMEOUT+1)) bits. Neither wraps: each stops at its terminal count.

## Timing
- `start` sampled high at edge E: `busy`=1 and the first coin on `coin` in cycle E+1.
- The machine registers the coin at the end of cycle E+1. Its response is visible in cycle E+2, which is the first GAP cycle, where it is sampled.
- The machine returns to s0 on the next 2'b00, so its response lasts exactly one cycle. It must be sampled in that cycle.
- Dispense sampled in cycle C: DONE state (`done`=1) in C+1, IDLE in C+2. The earliest new `start` that is accepted is the one sampled at the end of C+2.
- Coin pitch is `GAP`+1 cycles.
- Dispense sampled in the same cycle as gap expiry: dispense wins.

## Test plan
- **Exact pay with half coins.** `n_half`=3, `n_one`=0, GAP=1, `start` at edge 0 → `coin` = 01,00,01,00,01 in cycles 1..5. Machine `vend_out`=10 in cycle 6. `done`=1 in cycle 7 with `dispensed`=1, `change`=0, lefts=0.
- **Pay with change.** `n_one`=2 → `coin` = 10,00,10 in cycles 1..3. `vend_out`=11 in cycle 4. `done` in cycle 5 with `dispensed`=1, `change`=1.
- **Overpay stops early.** `n_one`=3, `n_half`=2 → only two 10 coins sent. `done` with `dispensed`=1, `change`=1, `left_one`=1, `left_half`=2.
- **Underpay timeout.** `n_half`=2, TIMEOUT=8 → two 01 coins, then the last coin's GAP plus 8 WAIT cycles, then `done` with `timeout_err`=1, `dispensed`=0.
- **Zero request.** `n_half`=`n_one`=0 → `done` within 2 cycles, `timeout_err`=1, `coin` stays 00.
- **Reset and ignored start.** Assert `rst` during a 10 coin → `coin`, `busy` and `done` are 0 immediately, with no further coins after release. `start` re-pulsed while `busy` → ignored, and the coin count is unchanged.
